// File: rtl/adc_scan_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_scan_sched_pkg : shared types and constants for the scan sequencer |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package adc_scan_sched_pkg;

    localparam int CH_W         = 3;
    localparam int ADC_W        = 12;
    localparam int ADC_DATA_MSB = 11;
    localparam int ADC_DATA_LSB = 4;
    localparam int RES_W        = ADC_DATA_MSB - ADC_DATA_LSB + 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_CAPTURE   = 3'd4,
        S_GAP       = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/adc_scan_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_scan_sched_if : SPI-control and tagged-result signals of the      |
// | scan sequencer.  Revision: 1.0                                        |
// +----------------------------------------------------------------------+
interface adc_scan_sched_if;
    import adc_scan_sched_pkg::*;

    logic             spi_ready;
    logic             spi_start;
    logic [CH_W-1:0]  channel;
    logic [ADC_W-1:0] adc_data;
    logic             res_valid;
    logic [CH_W-1:0]  res_chan;
    logic [RES_W-1:0] res_data;
    logic             busy;

    modport master (
        input  spi_ready, adc_data,
        output spi_start, channel, res_valid, res_chan, res_data, busy
    );

    modport slave (
        output spi_ready, adc_data,
        input  spi_start, channel, res_valid, res_chan, res_data, busy
    );

endinterface
`default_nettype wire

// File: rtl/adc_scan_sched_rr_next_chan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_next_chan : first set mask bit strictly above cur, wrapping to 0   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_next_chan
    import adc_scan_sched_pkg::*;
#(
    parameter int NCHAN = 2
) (
    input  logic [NCHAN-1:0] mask_i,
    input  logic [CH_W-1:0]  cur_i,
    output logic [CH_W-1:0]  next_o,
    output logic             any_set_o
);

    int               idx;
    logic [NCHAN-1:0] sh;

    // Scan offsets from farthest to nearest so the nearest set bit wins;
    // offset NCHAN lands back on cur itself for a single-bit mask.
    always_comb begin
        next_o    = cur_i;
        any_set_o = |mask_i;
        idx       = 0;
        sh        = '0;
        for (int k = NCHAN; k >= 1; k--) begin
            idx = (int'(cur_i) + k) % NCHAN;
            sh  = mask_i >> idx;
            if (sh[0]) begin
                next_o = CH_W'(idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_scan_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_scan_sched : round-robin ADC scan sequencer with pipelined tags   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module adc_scan_sched
    import adc_scan_sched_pkg::*;
#(
    parameter int NCHAN    = 2,
    parameter int INTERVAL = 0,
    parameter int IW       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [NCHAN-1:0] chan_mask,
    adc_scan_sched_if.master bus
);

    // Counter runs from the ISSUE clock, so loading INTERVAL-1 puts the next
    // ISSUE exactly INTERVAL clocks after the current one.
    localparam logic [IW-1:0] RELOAD = (INTERVAL > 1) ? IW'(INTERVAL - 1) : '0;

    state_t           state_q, state_d;
    logic [CH_W-1:0]  channel_q, channel_d;
    logic [CH_W-1:0]  prev_chan_q, prev_chan_d;
    logic             prime_q, prime_d;
    logic [IW-1:0]    cnt_q, cnt_d;
    logic             res_valid_q, res_valid_d;
    logic [CH_W-1:0]  res_chan_q, res_chan_d;
    logic [RES_W-1:0] res_data_q, res_data_d;

    logic [CH_W-1:0]  rr_cur;
    logic [CH_W-1:0]  rr_next;
    logic             rr_any;
    logic             run_ok;
    logic             unused_adc_lsbs;

    // From IDLE, searching above the top channel wraps to the lowest set bit.
    assign rr_cur = (state_q == S_IDLE) ? CH_W'(NCHAN - 1) : channel_q;
    assign run_ok = enable & rr_any;

    rr_next_chan #(.NCHAN(NCHAN)) u_rr (
        .mask_i    (chan_mask),
        .cur_i     (rr_cur),
        .next_o    (rr_next),
        .any_set_o (rr_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            channel_q   <= '0;
            prev_chan_q <= '0;
            prime_q     <= 1'b1;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_chan_q  <= '0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            channel_q   <= channel_d;
            prev_chan_q <= prev_chan_d;
            prime_q     <= prime_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_chan_q  <= res_chan_d;
            res_data_q  <= res_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        channel_d   = channel_q;
        prev_chan_d = prev_chan_q;
        prime_d     = prime_q;
        cnt_d       = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        res_valid_d = 1'b0;
        res_chan_d  = res_chan_q;
        res_data_d  = res_data_q;
        case (state_q)
            S_IDLE: begin
                if (run_ok && bus.spi_ready) begin
                    state_d   = S_ISSUE;
                    channel_d = rr_next;
                end
            end
            S_ISSUE: begin
                cnt_d   = RELOAD;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!bus.spi_ready) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (bus.spi_ready) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // The ADC returns the conversion addressed in the previous frame.
                if (!prime_q) begin
                    res_valid_d = 1'b1;
                    res_chan_d  = prev_chan_q;
                    res_data_d  = bus.adc_data[ADC_DATA_MSB:ADC_DATA_LSB];
                end
                prime_d     = 1'b0;
                prev_chan_d = channel_q;
                if (!run_ok) begin
                    state_d = S_IDLE;
                    prime_d = 1'b1;
                end else if (cnt_q > IW'(1)) begin
                    state_d = S_GAP;
                end else begin
                    state_d   = S_ISSUE;
                    channel_d = rr_next;
                end
            end
            S_GAP: begin
                if (!run_ok) begin
                    state_d = S_IDLE;
                    prime_d = 1'b1;
                end else if (cnt_q <= IW'(1)) begin
                    state_d   = S_ISSUE;
                    channel_d = rr_next;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.spi_start    = (state_q == S_ISSUE);
    assign bus.channel      = channel_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.res_valid    = res_valid_q;
    assign bus.res_chan     = res_chan_q;
    assign bus.res_data     = res_data_q;
    assign unused_adc_lsbs  = ^bus.adc_data[ADC_DATA_LSB-1:0];

endmodule
`default_nettype wire
